jamma_joy_scan: RTL
===================

JAMMA_JOY_SCAN -- requirements
Module: jamma_joy_scan

Interface
REQ-001 Parameter SETTLE, default 4: number of clk_12 cycles JSELECT is held in each phase before sampling; legal minimum 3.
REQ-002 Parameter DB_SCANS, default 4: number of consecutive differing samples needed to accept a bit change; range 2..7.
REQ-003 Parameter COIN_LEN, default 24'd1200000: coin output pulse width in clk_12 cycles (100 ms at 12 MHz); must be at least 1.
REQ-004 Port clk_12, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 Port RESET_L, input, 1 bit: reset, synchronous and active-low.
REQ-006 Port JJOY, input, 8 bits: shared JAMMA joystick/start bus, active-low, multiplexed by JSELECT.
REQ-007 Port JOYSTICK, input, 6 bits: local DB9 joystick, active-low; merged into player 1 only.
REQ-008 Port JCOIN, input, 2 bits: coin switches, active-low, asynchronous.
REQ-009 Port JSELECT, output, 1 bit: external splitter select; 0 selects player 1, 1 selects player 2.
REQ-010 Port joystick1, output, 8 bits: debounced player 1 word, active-low; [7] is start.
REQ-011 Port joystick2, output, 8 bits: debounced player 2 word, active-low.
REQ-012 Port coin_out, output, 2 bits: stretched coin pulses, active-low.
REQ-013 Port scan_tick, output, 1 bit: one-cycle high strobe marking the end of each full scan.

Function
REQ-014 JJOY and JCOIN shall each pass through a 2-flop synchronizer before any use.
REQ-015 Scan FSM shall have four states, cycling P1_WAIT -> P1_SAMPLE -> P2_WAIT -> P2_SAMPLE -> P1_WAIT.
REQ-016 Each WAIT state shall last exactly SETTLE cycles and each SAMPLE state exactly 1 cycle, giving a scan period of 2*(SETTLE+1) cycles.
REQ-017 JSELECT shall be a registered output: 0 in P1_* states, 1 in P2_* states.
REQ-018 In P1_SAMPLE the player 1 sample shall be synchronized JJOY AND {2'b11, JOYSTICK}.
REQ-019 In P2_SAMPLE the player 2 sample shall be synchronized JJOY; coins shall also be sampled in P2_SAMPLE.
REQ-020 Each of the 18 debounced bits (8 + 8 + 2 coin) shall have its own 3-bit counter, updated only on its own sample cycle.
REQ-021 Debounce rule, per sample: if sample == output bit, counter <= 0.
REQ-022 Debounce rule, per sample: otherwise counter increments; when the incremented value equals DB_SCANS, the output bit <= sample and counter <= 0 in the same cycle.
REQ-023 Debounce change latency shall be exactly DB_SCANS samples of that player; any mismatch run shorter than that shall produce no change.
REQ-024 Coin stretcher, per channel, independent: a 1->0 transition of the debounced coin bit shall start a down-counter loaded with COIN_LEN.
REQ-025 coin_out[n] shall go low on the cycle after the debounced edge and stay low for exactly COIN_LEN cycles.
REQ-026 A new coin edge during an active pulse shall be ignored (no retrigger, no queueing).
REQ-027 Simultaneous edges on both coin channels shall produce two independent, overlapping pulses.
REQ-028 scan_tick shall be high for the single cycle after each P2_SAMPLE.

Reset
REQ-029 While RESET_L=0 at a clk_12 edge: FSM <= P1_WAIT with wait counter 0; JSELECT <= 0.
REQ-030 While RESET_L=0 at a clk_12 edge: joystick1/joystick2 <= 8'hFF; coin_out <= 2'b11; scan_tick <= 0.
REQ-031 While RESET_L=0 at a clk_12 edge: all debounce and coin counters <= 0; synchronizer flops <= all ones.
REQ-032 Reset asserted mid-scan or mid-pulse shall abort immediately at the next edge; after release the first P1_SAMPLE occurs SETTLE+1 cycles later.

Verification (SETTLE=4, DB_SCANS=4, COIN_LEN=20; scan period 10)
REQ-033 Reset, then release -> outputs FF/FF/11; JSELECT low 5 cycles, high 5 cycles, repeating; scan_tick every 10 cycles.
REQ-034 JJOY=8'hFE while JSELECT=0, 8'hFF while JSELECT=1 -> joystick1=8'hFE after the 4th P1 sample; joystick2 stays 8'hFF.
REQ-035 JJOY bit3 low for 3 P2 scans, then high -> joystick2 never changes; 4 scans low -> joystick2=8'hF7.
REQ-036 JOYSTICK=6'b111011, JJOY=8'hFF -> joystick1=8'hFB after 4 scans; joystick2 stays 8'hFF.
REQ-037 JCOIN=2'b00 held for 10 scans -> both coin_out bits low for exactly 20 cycles, once each; JCOIN released and re-pressed during the pulse -> no extension.
REQ-038 RESET_L=0 for 1 cycle mid coin pulse -> coin_out=2'b11 and all outputs at reset values on the next edge.

Source files
------------

// File: rtl/jamma_joy_scan.sv
// JAMMA two-player joystick scanner: drives the splitter select, debounces both players
// and the coin switches, and stretches each coin press into a fixed-width active-low pulse.
module jamma_joy_scan #(
    parameter int unsigned SETTLE   = 4,
    parameter int unsigned DB_SCANS = 4,
    parameter logic [23:0] COIN_LEN = 24'd1200000
) (
    input  logic       clk_12,
    input  logic       RESET_L,
    input  logic [7:0] JJOY,
    input  logic [5:0] JOYSTICK,
    input  logic [1:0] JCOIN,
    output logic       JSELECT,
    output logic [7:0] joystick1,
    output logic [7:0] joystick2,
    output logic [1:0] coin_out,
    output logic       scan_tick
);

    localparam int unsigned WaitW = $clog2(SETTLE);
    localparam logic [WaitW-1:0] WaitLast = WaitW'(SETTLE - 1);
    localparam logic [2:0] DbLimit = 3'(DB_SCANS);

    typedef enum logic [1:0] {StP1Wait, StP1Sample, StP2Wait, StP2Sample} scan_state_e;

    scan_state_e      state_q, state_d;
    logic [WaitW-1:0] wait_q, wait_d;
    logic             jselect_q, jselect_d;
    logic             scan_tick_q, scan_tick_d;
    logic             samp1, samp2;

    logic [7:0]        jjoy_s1_q, jjoy_s2_q;
    logic [1:0]        coin_s1_q, coin_s2_q;
    logic [7:0]        joy1_q, joy1_d, joy2_q, joy2_d;
    logic [1:0]        coin_db_q, coin_db_d;
    logic [7:0][2:0]   cnt1_q, cnt1_d, cnt2_q, cnt2_d;
    logic [1:0][2:0]   cntc_q, cntc_d;
    logic [1:0][23:0]  pulse_q, pulse_d;
    logic [7:0]        p1_smp;

    // Returns {new output bit, new counter} for one debounce step.
    function automatic logic [3:0] db_step(input logic smp, input logic cur,
                                           input logic [2:0] cnt);
        logic [2:0] inc;
        inc = cnt + 3'd1;
        if (smp == cur) begin
            return {cur, 3'd0};
        end else if (inc == DbLimit) begin
            return {smp, 3'd0};
        end else begin
            return {cur, inc};
        end
    endfunction

    always_ff @(posedge clk_12) begin
        if (!RESET_L) begin
            state_q     <= StP1Wait;
            wait_q      <= '0;
            jselect_q   <= 1'b0;
            scan_tick_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            jselect_q   <= jselect_d;
            scan_tick_q <= scan_tick_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = '0;
        unique case (state_q)
            StP1Wait: begin
                if (wait_q == WaitLast) state_d = StP1Sample;
                else                    wait_d  = wait_q + 1'b1;
            end
            StP1Sample: state_d = StP2Wait;
            StP2Wait: begin
                if (wait_q == WaitLast) state_d = StP2Sample;
                else                    wait_d  = wait_q + 1'b1;
            end
            StP2Sample: state_d = StP1Wait;
            default:    state_d = StP1Wait;
        endcase
    end

    always_comb begin
        jselect_d   = (state_d == StP2Wait) || (state_d == StP2Sample);
        scan_tick_d = (state_q == StP2Sample);
        samp1       = (state_q == StP1Sample);
        samp2       = (state_q == StP2Sample);
    end

    assign p1_smp = jjoy_s2_q & {2'b11, JOYSTICK};

    always_comb begin
        joy1_d    = joy1_q;
        joy2_d    = joy2_q;
        coin_db_d = coin_db_q;
        cnt1_d    = cnt1_q;
        cnt2_d    = cnt2_q;
        cntc_d    = cntc_q;
        pulse_d   = pulse_q;
        if (samp1) begin
            for (int i = 0; i < 8; i++) begin
                {joy1_d[i], cnt1_d[i]} = db_step(p1_smp[i], joy1_q[i], cnt1_q[i]);
            end
        end
        if (samp2) begin
            for (int i = 0; i < 8; i++) begin
                {joy2_d[i], cnt2_d[i]} = db_step(jjoy_s2_q[i], joy2_q[i], cnt2_q[i]);
            end
            for (int i = 0; i < 2; i++) begin
                {coin_db_d[i], cntc_d[i]} = db_step(coin_s2_q[i], coin_db_q[i], cntc_q[i]);
            end
        end
        // A falling debounced coin only loads an idle stretcher; active pulses are not extended.
        for (int i = 0; i < 2; i++) begin
            if (pulse_q[i] != 24'd0) begin
                pulse_d[i] = pulse_q[i] - 24'd1;
            end else if (coin_db_q[i] && !coin_db_d[i]) begin
                pulse_d[i] = COIN_LEN;
            end
        end
    end

    always_ff @(posedge clk_12) begin
        if (!RESET_L) begin
            jjoy_s1_q <= '1;
            jjoy_s2_q <= '1;
            coin_s1_q <= '1;
            coin_s2_q <= '1;
            joy1_q    <= 8'hFF;
            joy2_q    <= 8'hFF;
            coin_db_q <= 2'b11;
            cnt1_q    <= '0;
            cnt2_q    <= '0;
            cntc_q    <= '0;
            pulse_q   <= '0;
        end else begin
            jjoy_s1_q <= JJOY;
            jjoy_s2_q <= jjoy_s1_q;
            coin_s1_q <= JCOIN;
            coin_s2_q <= coin_s1_q;
            joy1_q    <= joy1_d;
            joy2_q    <= joy2_d;
            coin_db_q <= coin_db_d;
            cnt1_q    <= cnt1_d;
            cnt2_q    <= cnt2_d;
            cntc_q    <= cntc_d;
            pulse_q   <= pulse_d;
        end
    end

    assign JSELECT     = jselect_q;
    assign scan_tick   = scan_tick_q;
    assign joystick1   = joy1_q;
    assign joystick2   = joy2_q;
    assign coin_out[0] = (pulse_q[0] == 24'd0);
    assign coin_out[1] = (pulse_q[1] == 24'd0);

endmodule
